// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared PS/2 set-2 decoder definitions: prefix bytes, keyboard control codes and FSM encodings.
package ps2_scancode_decoder_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    localparam logic [7:0] PS2_CTL_ERR0   = 8'h00;
    localparam logic [7:0] PS2_CTL_BAT    = 8'hAA;
    localparam logic [7:0] PS2_CTL_ACK    = 8'hFA;
    localparam logic [7:0] PS2_CTL_RESEND = 8'hFE;
    localparam logic [7:0] PS2_CTL_ERR1   = 8'hFF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_E0   = 3'd1;
    localparam logic [2:0] ST_F0   = 3'd2;
    localparam logic [2:0] ST_E0F0 = 3'd3;
    localparam logic [2:0] ST_SKIP = 3'd4;

    // Pause sends E1 followed by seven more bytes that carry no usable key event.
    localparam logic [2:0] PAUSE_SKIP_LEN = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_E0   = ST_E0,
        S_F0   = ST_F0,
        S_E0F0 = ST_E0F0,
        S_SKIP = ST_SKIP
    } state_e;

    function automatic logic isCtrlCode(input logic [7:0] b);
        return (b == PS2_CTL_ERR0) || (b == PS2_CTL_BAT) || (b == PS2_CTL_ACK) ||
               (b == PS2_CTL_RESEND) || (b == PS2_CTL_ERR1);
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Byte-in / key-event-out bundle of the scan-code decoder; slave is the decoder side.
interface ps2_scancode_decoder_if #(parameter int CNT_W = 8);

    logic [7:0]       kb_data;
    logic             kb_ready;
    logic             kb_ack_n;
    logic             evt_valid;
    logic             evt_make;
    logic             evt_ext;
    logic [7:0]       evt_code;
    logic             evt_repeat;
    logic [7:0]       evt_ascii;
    logic             key_held;
    logic [CNT_W-1:0] press_count;

    modport master (
        output kb_data, kb_ready,
        input  kb_ack_n, evt_valid, evt_make, evt_ext, evt_code, evt_repeat,
               evt_ascii, key_held, press_count
    );

    modport slave (
        input  kb_data, kb_ready,
        output kb_ack_n, evt_valid, evt_make, evt_ext, evt_code, evt_repeat,
               evt_ascii, key_held, press_count
    );

endinterface

// File: rtl/ps2_scancode_decoder_ascii_rom.sv
// Scan-code set 2 to ASCII table: lowercase letters, digits, space, enter and backspace.
// Only instantiated when PS2_ASCII_LUT_EN is defined.
module ps2_ascii_rom (
    input  logic [7:0] code_i,
    output logic [7:0] ascii_o
);

    always_comb begin
        ascii_o = 8'h00;
        case (code_i)
            8'h1C: ascii_o = 8'h61;  8'h32: ascii_o = 8'h62;  8'h21: ascii_o = 8'h63;
            8'h23: ascii_o = 8'h64;  8'h24: ascii_o = 8'h65;  8'h2B: ascii_o = 8'h66;
            8'h34: ascii_o = 8'h67;  8'h33: ascii_o = 8'h68;  8'h43: ascii_o = 8'h69;
            8'h3B: ascii_o = 8'h6A;  8'h42: ascii_o = 8'h6B;  8'h4B: ascii_o = 8'h6C;
            8'h3A: ascii_o = 8'h6D;  8'h31: ascii_o = 8'h6E;  8'h44: ascii_o = 8'h6F;
            8'h4D: ascii_o = 8'h70;  8'h15: ascii_o = 8'h71;  8'h2D: ascii_o = 8'h72;
            8'h1B: ascii_o = 8'h73;  8'h2C: ascii_o = 8'h74;  8'h3C: ascii_o = 8'h75;
            8'h2A: ascii_o = 8'h76;  8'h1D: ascii_o = 8'h77;  8'h22: ascii_o = 8'h78;
            8'h35: ascii_o = 8'h79;  8'h1A: ascii_o = 8'h7A;
            8'h45: ascii_o = 8'h30;  8'h16: ascii_o = 8'h31;  8'h1E: ascii_o = 8'h32;
            8'h26: ascii_o = 8'h33;  8'h25: ascii_o = 8'h34;  8'h2E: ascii_o = 8'h35;
            8'h36: ascii_o = 8'h36;  8'h3D: ascii_o = 8'h37;  8'h3E: ascii_o = 8'h38;
            8'h46: ascii_o = 8'h39;
            8'h29: ascii_o = 8'h20;  8'h5A: ascii_o = 8'h0D;  8'h66: ascii_o = 8'h08;
            default: ascii_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops set-2 scan-code bytes from the PS/2 FIFO, strips E0/F0/E1 prefixes and emits key events.
// Define PS2_ASCII_LUT_EN to populate evt_ascii from ps2_ascii_rom; otherwise it stays 0.
module ps2_scancode_decoder
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic rst,
    ps2_scancode_decoder_if.slave bus
);

    state_e           state_q, state_d;
    logic [2:0]       skipCnt_q, skipCnt_d;
    logic             held_q;
    logic             heldExt_q;
    logic [7:0]       heldCode_q;
    logic [CNT_W-1:0] pressCount_q;
    logic             evtValid_q, evtMake_q, evtExt_q, evtRepeat_q;
    logic [7:0]       evtCode_q, evtAscii_q;

    logic             consume;
    logic             emit, emitMake, emitExt;
    logic             sameKey;
    logic [7:0]       asciiNext;

    // The decoder never stalls: every byte offered outside reset is popped at once.
    assign consume      = bus.kb_ready & ~rst;
    assign bus.kb_ack_n = ~consume;

    assign sameKey = held_q && (heldExt_q == emitExt) && (heldCode_q == bus.kb_data);

`ifdef PS2_ASCII_LUT_EN
    logic [7:0] romAscii;

    ps2_ascii_rom uAsciiRom (
        .code_i  (bus.kb_data),
        .ascii_o (romAscii)
    );

    assign asciiNext = emitExt ? 8'h00 : romAscii;
`else
    assign asciiNext = 8'h00;
`endif

    always_comb begin
        state_d   = state_q;
        skipCnt_d = skipCnt_q;
        emit      = 1'b0;
        emitMake  = 1'b0;
        emitExt   = 1'b0;
        if (consume) begin
            if (state_q == S_SKIP) begin
                skipCnt_d = skipCnt_q - 3'd1;
                if (skipCnt_q == 3'd1) state_d = S_IDLE;
            end else if (bus.kb_data == PS2_PFX_PAUSE) begin
                state_d   = S_SKIP;
                skipCnt_d = PAUSE_SKIP_LEN;
            end else if (bus.kb_data == PS2_PFX_EXT) begin
                state_d = S_E0;
            end else if (bus.kb_data == PS2_PFX_BRK) begin
                // A break prefix keeps whatever extended-ness was already seen.
                state_d = (state_q == S_E0 || state_q == S_E0F0) ? S_E0F0 : S_F0;
            end else if (!(state_q == S_IDLE && isCtrlCode(bus.kb_data))) begin
                emit     = 1'b1;
                emitMake = (state_q == S_IDLE) || (state_q == S_E0);
                emitExt  = (state_q == S_E0) || (state_q == S_E0F0);
                state_d  = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            skipCnt_q    <= 3'd0;
            held_q       <= 1'b0;
            heldExt_q    <= 1'b0;
            heldCode_q   <= 8'h00;
            pressCount_q <= '0;
            evtValid_q   <= 1'b0;
            evtMake_q    <= 1'b0;
            evtExt_q     <= 1'b0;
            evtCode_q    <= 8'h00;
            evtRepeat_q  <= 1'b0;
            evtAscii_q   <= 8'h00;
        end else begin
            state_q    <= state_d;
            skipCnt_q  <= skipCnt_d;
            evtValid_q <= emit;
            if (emit) begin
                evtMake_q   <= emitMake;
                evtExt_q    <= emitExt;
                evtCode_q   <= bus.kb_data;
                evtAscii_q  <= asciiNext;
                evtRepeat_q <= emitMake & sameKey;
                // Only one key is tracked; a new make replaces it, a break of another key is ignored.
                if (emitMake && !sameKey) begin
                    held_q       <= 1'b1;
                    heldExt_q    <= emitExt;
                    heldCode_q   <= bus.kb_data;
                    pressCount_q <= pressCount_q + CNT_W'(1);
                end else if (!emitMake && sameKey) begin
                    held_q <= 1'b0;
                end
            end
        end
    end

    assign bus.evt_valid   = evtValid_q;
    assign bus.evt_make    = evtMake_q;
    assign bus.evt_ext     = evtExt_q;
    assign bus.evt_code    = evtCode_q;
    assign bus.evt_repeat  = evtRepeat_q;
    assign bus.evt_ascii   = evtAscii_q;
    assign bus.key_held    = held_q;
    assign bus.press_count = pressCount_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: prefixes, repeats, Pause skipping, reset and counter wrap.
module tb_ps2_scancode_decoder;

`ifdef PS2_ASCII_LUT_EN
    localparam logic [7:0] EXP_ASCII_1C = 8'h61;
`else
    localparam logic [7:0] EXP_ASCII_1C = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst;
    int   passCount  = 0;
    int   checkCount = 0;
    int   failCount  = 0;
    int   pulseCount = 0;
    int   pulseBase  = 0;

    always #5 clk = ~clk;

    ps2_scancode_decoder_if #(.CNT_W(8)) bus ();

    ps2_scancode_decoder #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Count every event pulse so sequences can be checked for exact pulse totals.
    always @(negedge clk) if (bus.evt_valid === 1'b1) pulseCount++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte for exactly one cycle; returns on the negedge after it was consumed.
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        bus.kb_data  = b;
        bus.kb_ready = 1'b1;
        @(negedge clk);
        bus.kb_ready = 1'b0;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkEvent(input string tag, input logic make, input logic ext,
                              input logic [7:0] code, input logic rpt, input logic [7:0] ascii);
        checkOutput({tag, ".valid"},  bus.evt_valid,  1);
        checkOutput({tag, ".make"},   bus.evt_make,   make);
        checkOutput({tag, ".ext"},    bus.evt_ext,    ext);
        checkOutput({tag, ".code"},   bus.evt_code,   code);
        checkOutput({tag, ".repeat"}, bus.evt_repeat, rpt);
        checkOutput({tag, ".ascii"},  bus.evt_ascii,  ascii);
    endtask

    task automatic sendBurst(input int triples);
        @(negedge clk);
        for (int i = 0; i < triples; i++) begin
            for (int j = 0; j < 3; j++) begin
                bus.kb_data  = (j == 1) ? 8'hF0 : 8'h1C;
                bus.kb_ready = 1'b1;
                @(negedge clk);
            end
        end
        bus.kb_ready = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        bus.kb_data  = 8'h00;
        bus.kb_ready = 1'b0;
        repeat (2) @(negedge clk);
        bus.kb_ready = 1'b1;
        #1;
        checkOutput("ackDuringReset", bus.kb_ack_n, 1);
        bus.kb_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst.valid", bus.evt_valid, 0);
        checkOutput("rst.held",  bus.key_held, 0);
        checkOutput("rst.count", bus.press_count, 0);
        checkOutput("rst.code",  bus.evt_code, 0);

        $display("[TB] single make 1C");
        @(negedge clk);
        bus.kb_data  = 8'h1C;
        bus.kb_ready = 1'b1;
        #1;
        checkOutput("ackWhenReady", bus.kb_ack_n, 0);
        @(negedge clk);
        bus.kb_ready = 1'b0;
        checkEvent("t1", 1, 0, 8'h1C, 0, EXP_ASCII_1C);
        checkOutput("t1.held",  bus.key_held, 1);
        checkOutput("t1.count", bus.press_count, 1);
        @(negedge clk);
        checkOutput("t1.pulseEnds", bus.evt_valid, 0);
        checkOutput("t1.codeHolds", bus.evt_code, 8'h1C);

        $display("[TB] typematic repeat and break");
        applyReset();
        applyStimulus(8'h1C);
        checkOutput("t2.count1", bus.press_count, 1);
        applyStimulus(8'h1C);
        checkEvent("t2.rep", 1, 0, 8'h1C, 1, EXP_ASCII_1C);
        checkOutput("t2.repCount", bus.press_count, 1);
        applyStimulus(8'hF0);
        checkOutput("t2.prefixNoEvt", bus.evt_valid, 0);
        applyStimulus(8'h1C);
        checkEvent("t2.brk", 0, 0, 8'h1C, 0, EXP_ASCII_1C);
        checkOutput("t2.held", bus.key_held, 0);

        $display("[TB] extended make/break");
        #1;
        pulseBase = pulseCount;
        applyStimulus(8'hE0);
        applyStimulus(8'h75);
        checkEvent("t3.make", 1, 1, 8'h75, 0, 8'h00);
        checkOutput("t3.count", bus.press_count, 2);
        checkOutput("t3.heldOn", bus.key_held, 1);
        applyStimulus(8'hE0);
        applyStimulus(8'hF0);
        applyStimulus(8'h75);
        checkEvent("t3.brk", 0, 1, 8'h75, 0, 8'h00);
        checkOutput("t3.heldOff", bus.key_held, 0);
        @(negedge clk);
        #1;
        checkOutput("t3.pulses", pulseCount - pulseBase, 2);

        $display("[TB] Pause sequence skipped");
        pulseBase = pulseCount;
        applyStimulus(8'hE1);
        applyStimulus(8'h14);
        applyStimulus(8'h77);
        applyStimulus(8'hE1);
        applyStimulus(8'hF0);
        applyStimulus(8'h14);
        applyStimulus(8'hF0);
        applyStimulus(8'h77);
        #1;
        checkOutput("t4.noPulses", pulseCount - pulseBase, 0);
        applyStimulus(8'h1C);
        checkEvent("t4.make", 1, 0, 8'h1C, 0, EXP_ASCII_1C);
        checkOutput("t4.count", bus.press_count, 3);

        $display("[TB] control codes and reset mid-sequence");
        #1;
        pulseBase = pulseCount;
        applyStimulus(8'hAA);
        applyStimulus(8'hFA);
        applyStimulus(8'hF0);
        applyReset();
        #1;
        checkOutput("t5.noPulses", pulseCount - pulseBase, 0);
        checkOutput("t5.heldCleared", bus.key_held, 0);
        checkOutput("t5.countCleared", bus.press_count, 0);
        applyStimulus(8'h1C);
        checkEvent("t5.make", 1, 0, 8'h1C, 0, EXP_ASCII_1C);
        checkOutput("t5.count", bus.press_count, 1);

        $display("[TB] back-to-back counter wrap");
        applyReset();
        #1;
        pulseBase = pulseCount;
        sendBurst(255);
        checkOutput("t6.count255", bus.press_count, 8'hFF);
        checkOutput("t6.pulses510", pulseCount - pulseBase, 510);
        checkOutput("t6.heldOff", bus.key_held, 0);
        sendBurst(1);
        checkOutput("t6.countWrap", bus.press_count, 0);
        checkOutput("t6.pulses512", pulseCount - pulseBase, 512);
        checkOutput("t6.lastCode", bus.evt_code, 8'h1C);
        checkOutput("t6.lastMake", bus.evt_make, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
